// File: rtl/idct_8x8_seq.sv
// idct_8x8_seq: sequential 8x8 inverse DCT, row pass then column pass on one shared MAC
module idct_8x8_seq #(
  parameter int IN_W  = 16,
  parameter int MID_W = 18,
  parameter int OUT_W = 16,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
);
  localparam int ACC_W = MID_W + 14;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -ACC_W'(2 ** (OUT_W - 1));
  typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;
  state_t st_q, st_d;
  logic [9:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod, sum, rnd;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d, sat;
  logic signed [IN_W-1:0]  coef_q [64];
  logic signed [MID_W-1:0] mid_q [64];
  logic signed [OUT_W-1:0] res_q [64];
  logic [2:0] ki, km, ko, tn;
  logic [4:0] m, mf, mg;
  logic [6:0] mag;
  logic [5:0] nxt;
  logic signed [7:0] tv;
  logic signed [MID_W-1:0] a;
  logic mac_we;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  // Shared MAC: counter is {outer, middle, inner}; cosine entry folded from the phase (2n+1)k mod 32
  always_comb begin
    ki = cnt_q[2:0];
    km = cnt_q[5:3];
    ko = cnt_q[8:6];
    tn = st_q == S_ROW ? km : ko;
    m  = {1'b0, tn, 1'b1} * {2'b0, ki};
    mf = m > 5'd16 ? 5'd0 - m : m;
    mg = mf > 5'd8 ? 5'd16 - mf : mf;
    mag = 7'd0;
    case (mg)
      5'd0: mag = 7'd64;
      5'd1: mag = 7'd63;
      5'd2: mag = 7'd59;
      5'd3: mag = 7'd53;
      5'd4: mag = 7'd45;
      5'd5: mag = 7'd36;
      5'd6: mag = 7'd24;
      5'd7: mag = 7'd12;
      default: mag = 7'd0;
    endcase
    tv   = ki == 3'd0 ? 8'sd32 : mf > 5'd8 ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    a    = st_q == S_ROW ? MID_W'(coef_q[{ko, ki}]) : mid_q[{ki, km}];
    prod = ACC_W'(a) * ACC_W'(tv);
    sum  = (ki == 3'd0 ? '0 : acc_q) + prod;
    rnd  = (sum + (ACC_W'(1) <<< (FRAC - 1))) >>> FRAC;
    sat  = rnd > SMAX ? SMAX[OUT_W-1:0] : rnd < SMIN ? SMIN[OUT_W-1:0] : rnd[OUT_W-1:0];
    mac_we = ki == 3'd7 && (st_q == S_ROW || (st_q == S_COL && !cnt_q[9]));
  end
  // Coefficient, row-pass and result buffers
  always_ff @(posedge clk) begin
    if (in_valid && in_ready_q) coef_q[cnt_q[5:0]] <= in_data;
    if (mac_we && st_q == S_ROW) mid_q[{ko, km}] <= rnd[MID_W-1:0];
    if (mac_we && st_q == S_COL) res_q[{ko, km}] <= sat;
  end
  // Next-state and registered handshake outputs; COL has one idle cycle before OUT
  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    acc_d       = sum;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    nxt         = cnt_q[5:0] + 6'd1;
    case (st_q)
      S_LOAD: if (in_valid) begin
        cnt_d = cnt_q + 10'd1;
        if (cnt_q[5:0] == 6'd63) begin
          st_d       = S_ROW;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_ROW: begin
        cnt_d = cnt_q == 10'd511 ? '0 : cnt_q + 10'd1;
        st_d  = cnt_q == 10'd511 ? S_COL : S_ROW;
      end
      S_COL: begin
        cnt_d = cnt_q + 10'd1;
        if (cnt_q == 10'd512) begin
          st_d        = S_OUT;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = res_q[0];
          out_last_d  = 1'b0;
        end
      end
      default: if (out_ready) begin
        cnt_d      = {4'd0, nxt};
        out_data_d = res_q[nxt];
        out_last_d = nxt == 6'd63;
        if (cnt_q[5:0] == 6'd63) begin
          st_d        = S_LOAD;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          out_data_d  = out_data_q;
          out_last_d  = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
    endcase
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= S_LOAD;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end
endmodule
